invader_fleet: RTL and testbench

Parametrised invader formation controller: holds a ROWS×COLS grid of invaders, marches it horizontally with edge reversal and drop, and speeds up as invaders are destroyed. Tests the player bullet against live cells and pulses `invader_collision` toward `score_logic`. Publishes the fleet origin, alive mask and animation phase for `vga_controller`. Generalises the fixed single-sprite handling in the game top into a configurable multi-sprite block with hit detection and landing/clear detection.

---
 rtl/invader_fleet_pkg.sv | 24 ++
 rtl/fleet_hit_detect.sv | 54 +++++
 rtl/invader_fleet.sv | 219 +++++++++++++++++++++
 tb/tb_invader_fleet.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/invader_fleet_pkg.sv
// rtl/invader_fleet_pkg.sv - shared constants, state encoding and helpers for the invader fleet
package invader_fleet_pkg;

   // Default playfield bounds (inclusive) and landing line
   localparam int SCREEN_X_MIN  = 0;
   localparam int SCREEN_X_MAX  = 639;
   localparam int SCREEN_LAND_Y = 440;

   // Pixel coordinate width and signed intermediate width
   localparam int COORD_W = 10;
   localparam int CALC_W  = 11;

   typedef enum logic [1:0] {
      ST_MARCH   = 2'd0,
      ST_LANDED  = 2'd1,
      ST_CLEARED = 2'd2
   } fleet_state_e;

   // Widen an unsigned pixel coordinate into a non-negative signed intermediate
   function automatic logic signed [CALC_W-1:0] to_calc(input logic [COORD_W-1:0] v);
      return signed'({1'b0, v});
   endfunction

endpackage

// File: rtl/fleet_hit_detect.sv
// rtl/fleet_hit_detect.sv - combinational mapping of a bullet point onto a live fleet cell
module fleet_hit_detect
   import invader_fleet_pkg::*;
#(
   parameter int ROWS    = 5,
   parameter int COLS    = 11,
   parameter int INV_W   = 16,
   parameter int INV_H   = 16,
   parameter int PITCH_X = 32,
   parameter int PITCH_Y = 32
)(
   input  logic [COORD_W-1:0]   bullet_x,
   input  logic [COORD_W-1:0]   bullet_y,
   input  logic [COORD_W-1:0]   fleet_x,
   input  logic [COORD_W-1:0]   fleet_y,
   input  logic [ROWS*COLS-1:0] alive,
   output logic                 hit,
   output logic [7:0]           index
);

   localparam int PX_SH = $clog2(PITCH_X);
   localparam int PY_SH = $clog2(PITCH_Y);

   logic signed [CALC_W-1:0] rel_x;
   logic signed [CALC_W-1:0] rel_y;
   logic [CALC_W-1:0]        col;
   logic [CALC_W-1:0]        row;
   logic [CALC_W-1:0]        off_x;
   logic [CALC_W-1:0]        off_y;
   logic [CALC_W-1:0]        idx_w;
   logic                     in_cell;
   logic                     alive_bit;

   // Pitches are powers of two, so cell and in-cell offset are a shift and a mask
   always_comb begin
      rel_x     = to_calc(bullet_x) - to_calc(fleet_x);
      rel_y     = to_calc(bullet_y) - to_calc(fleet_y);
      col       = $unsigned(rel_x) >> PX_SH;
      row       = $unsigned(rel_y) >> PY_SH;
      off_x     = $unsigned(rel_x) & CALC_W'(PITCH_X - 1);
      off_y     = $unsigned(rel_y) & CALC_W'(PITCH_Y - 1);
      in_cell   = !rel_x[CALC_W-1] && !rel_y[CALC_W-1]
                  && (col < CALC_W'(COLS)) && (row < CALC_W'(ROWS))
                  && (off_x < CALC_W'(INV_W)) && (off_y < CALC_W'(INV_H));
      idx_w     = row * CALC_W'(COLS) + col;
      alive_bit = 1'b0;
      for (int i = 0; i < ROWS*COLS; i++) begin
         if (idx_w == CALC_W'(i)) alive_bit = alive[i];
      end
      hit       = in_cell && alive_bit;
      index     = in_cell ? idx_w[7:0] : 8'd0;
   end

endmodule

// File: rtl/invader_fleet.sv
// rtl/invader_fleet.sv - marching invader formation with hit, landing and clear detection
module invader_fleet
   import invader_fleet_pkg::*;
#(
   parameter int ROWS        = 5,
   parameter int COLS        = 11,
   parameter int INV_W       = 16,
   parameter int INV_H       = 16,
   parameter int PITCH_X     = 32,
   parameter int PITCH_Y     = 32,
   parameter int START_X     = 64,
   parameter int START_Y     = 48,
   parameter int STEP_X      = 4,
   parameter int DROP_Y      = 16,
   parameter int X_MIN       = SCREEN_X_MIN,
   parameter int X_MAX       = SCREEN_X_MAX,
   parameter int LAND_Y      = SCREEN_LAND_Y,
   parameter int MIN_PERIOD  = 1,
   parameter int SPEED_SHIFT = 2
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame,
   input  logic                 restart,
   input  logic                 bullet_valid,
   input  logic [COORD_W-1:0]   bullet_x,
   input  logic [COORD_W-1:0]   bullet_y,
   output logic [COORD_W-1:0]   fleet_x,
   output logic [COORD_W-1:0]   fleet_y,
   output logic [ROWS*COLS-1:0] alive,
   output logic                 anim,
   output logic                 invader_collision,
   output logic [7:0]           hit_index,
   output logic                 landed,
   output logic                 cleared
);

   localparam int N     = ROWS * COLS;
   localparam int CNT_W = $clog2(N + 1);
   localparam int FC_W  = 16;

   localparam logic signed [CALC_W-1:0] PX_C     = CALC_W'(PITCH_X);
   localparam logic signed [CALC_W-1:0] PY_C     = CALC_W'(PITCH_Y);
   localparam logic signed [CALC_W-1:0] W_M1_C   = CALC_W'(INV_W - 1);
   localparam logic signed [CALC_W-1:0] H_M1_C   = CALC_W'(INV_H - 1);
   localparam logic signed [CALC_W-1:0] STEP_C   = CALC_W'(STEP_X);
   localparam logic signed [CALC_W-1:0] XMIN_C   = CALC_W'(X_MIN);
   localparam logic signed [CALC_W-1:0] XMAX_C   = CALC_W'(X_MAX);
   localparam logic signed [CALC_W-1:0] LAND_C   = CALC_W'(LAND_Y);

   logic [1:0]          rst_sync_q;
   logic                rst_n_int;

   fleet_state_e        state_q,  state_d;
   logic [COORD_W-1:0]  fx_q,     fx_d;
   logic [COORD_W-1:0]  fy_q,     fy_d;
   logic                dir_left_q, dir_left_d;
   logic [FC_W-1:0]     fcnt_q,   fcnt_d;
   logic [N-1:0]        alive_q,  alive_d;
   logic                anim_q,   anim_d;
   logic                coll_q,   coll_d;
   logic [7:0]          hidx_q,   hidx_d;

   logic [CNT_W-1:0]         alive_cnt;
   logic [COLS-1:0]          col_any;
   logic [ROWS-1:0]          row_any;
   logic signed [CALC_W-1:0] lcol, rcol, brow;
   logic signed [CALC_W-1:0] left_e, right_e, bottom_e;
   logic [FC_W-1:0]          period;
   logic                     step_due;
   logic                     hit_w;
   logic [7:0]               hit_idx_w;

   fleet_hit_detect #(
      .ROWS    (ROWS),
      .COLS    (COLS),
      .INV_W   (INV_W),
      .INV_H   (INV_H),
      .PITCH_X (PITCH_X),
      .PITCH_Y (PITCH_Y)
   ) u_hit (
      .bullet_x (bullet_x),
      .bullet_y (bullet_y),
      .fleet_x  (fx_q),
      .fleet_y  (fy_q),
      .alive    (alive_q),
      .hit      (hit_w),
      .index    (hit_idx_w)
   );

   // Reset asserts immediately but releases two clock edges later, in step with clk
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync_q <= 2'b00;
      else      rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n_int = rst_sync_q[1];

   // Live extent of the formation and population count, from the registered mask
   always_comb begin
      alive_cnt = '0;
      col_any   = '0;
      row_any   = '0;
      lcol      = '0;
      rcol      = '0;
      brow      = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (alive_q[r*COLS + c]) begin
               col_any[c] = 1'b1;
               row_any[r] = 1'b1;
            end
            alive_cnt = alive_cnt + CNT_W'(alive_q[r*COLS + c]);
         end
      end
      for (int c = COLS - 1; c >= 0; c--) if (col_any[c]) lcol = CALC_W'(c);
      for (int c = 0; c < COLS; c++)      if (col_any[c]) rcol = CALC_W'(c);
      for (int r = 0; r < ROWS; r++)      if (row_any[r]) brow = CALC_W'(r);
      left_e   = to_calc(fx_q) + lcol * PX_C;
      right_e  = to_calc(fx_q) + rcol * PX_C + W_M1_C;
      bottom_e = to_calc(fy_q) + brow * PY_C + H_M1_C;
      period   = FC_W'(MIN_PERIOD) + FC_W'(alive_cnt >> SPEED_SHIFT);
      // >= rather than == so a kill that shortens the period cannot strand the count
      step_due = frame && (fcnt_q >= period - FC_W'(1));
   end

   // Next-state: march/drop/reverse, hit bookkeeping, end-of-wave detection
   always_comb begin
      state_d    = state_q;
      fx_d       = fx_q;
      fy_d       = fy_q;
      dir_left_d = dir_left_q;
      fcnt_d     = fcnt_q;
      alive_d    = alive_q;
      anim_d     = anim_q;
      coll_d     = 1'b0;
      hidx_d     = hidx_q;
      if (state_q == ST_MARCH) begin
         if (alive_cnt == '0) begin
            state_d = ST_CLEARED;
         end else if (bottom_e >= LAND_C) begin
            state_d = ST_LANDED;
         end else if (frame) begin
            if (step_due) begin
               fcnt_d = '0;
               anim_d = ~anim_q;
               if (!dir_left_q) begin
                  if (right_e + STEP_C <= XMAX_C) begin
                     fx_d = fx_q + COORD_W'(STEP_X);
                  end else begin
                     fy_d       = fy_q + COORD_W'(DROP_Y);
                     dir_left_d = 1'b1;
                  end
               end else begin
                  if (left_e - STEP_C >= XMIN_C) begin
                     fx_d = fx_q - COORD_W'(STEP_X);
                  end else begin
                     fy_d       = fy_q + COORD_W'(DROP_Y);
                     dir_left_d = 1'b0;
                  end
               end
            end else begin
               fcnt_d = fcnt_q + FC_W'(1);
            end
         end
         // Hit is judged against the pre-step origin and lands alongside any step
         if (bullet_valid && hit_w) begin
            coll_d  = 1'b1;
            hidx_d  = hit_idx_w;
            alive_d = alive_q & ~(N'(1) << hit_idx_w);
         end
      end
      if (restart) begin
         state_d    = ST_MARCH;
         fx_d       = COORD_W'(START_X);
         fy_d       = COORD_W'(START_Y);
         dir_left_d = 1'b0;
         fcnt_d     = '0;
         alive_d    = '1;
         anim_d     = 1'b0;
         coll_d     = 1'b0;
         hidx_d     = '0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q    <= ST_MARCH;
         fx_q       <= COORD_W'(START_X);
         fy_q       <= COORD_W'(START_Y);
         dir_left_q <= 1'b0;
         fcnt_q     <= '0;
         alive_q    <= '1;
         anim_q     <= 1'b0;
         coll_q     <= 1'b0;
         hidx_q     <= '0;
      end else begin
         state_q    <= state_d;
         fx_q       <= fx_d;
         fy_q       <= fy_d;
         dir_left_q <= dir_left_d;
         fcnt_q     <= fcnt_d;
         alive_q    <= alive_d;
         anim_q     <= anim_d;
         coll_q     <= coll_d;
         hidx_q     <= hidx_d;
      end
   end

   assign fleet_x           = fx_q;
   assign fleet_y           = fy_q;
   assign alive             = alive_q;
   assign anim              = anim_q;
   assign invader_collision = coll_q;
   assign hit_index         = hidx_q;
   assign landed            = (state_q == ST_LANDED);
   assign cleared           = (state_q == ST_CLEARED);

endmodule

// File: tb/tb_invader_fleet.sv
// tb/tb_invader_fleet.sv - randomized and directed bench for invader_fleet against a reference model
module tb_invader_fleet;

   localparam int ROWS = 5;
   localparam int COLS = 11;
   localparam int N    = ROWS * COLS;

   logic          clk = 1'b0;
   logic          rst, frame, restart, bullet_valid;
   logic [9:0]    bullet_x, bullet_y;
   logic [9:0]    fleet_x, fleet_y;
   logic [N-1:0]  alive;
   logic          anim, invader_collision, landed, cleared;
   logic [7:0]    hit_index;

   always #5 clk = ~clk;

   invader_fleet dut (
      .clk               (clk),
      .rst               (rst),
      .frame             (frame),
      .restart           (restart),
      .bullet_valid      (bullet_valid),
      .bullet_x          (bullet_x),
      .bullet_y          (bullet_y),
      .fleet_x           (fleet_x),
      .fleet_y           (fleet_y),
      .alive             (alive),
      .anim              (anim),
      .invader_collision (invader_collision),
      .hit_index         (hit_index),
      .landed            (landed),
      .cleared           (cleared)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: origin, heading, frame count, per-cell alive flags, phase
   int m_x, m_y, m_dir, m_cnt, m_state, m_hidx;
   bit m_alive[N];
   bit m_anim, m_coll;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_x = 64; m_y = 48; m_dir = 1; m_cnt = 0; m_state = 0;
      m_anim = 0; m_coll = 0; m_hidx = 0;
      for (int i = 0; i < N; i++) m_alive[i] = 1;
   endtask

   task automatic model_edge();
      int cnt, lcol, rcol, brow, hit_i, bx, by, x0, y0;
      bit step;
      cnt = 0; lcol = COLS; rcol = -1; brow = -1; hit_i = -1; step = 0;
      if (restart) begin
         model_reset();
         return;
      end
      m_coll = 0;
      if (m_state != 0) return;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (m_alive[r*COLS + c]) begin
               cnt++;
               if (c < lcol) lcol = c;
               if (c > rcol) rcol = c;
               if (r > brow) brow = r;
            end
      bx = int'(bullet_x);
      by = int'(bullet_y);
      if (bullet_valid)
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
               x0 = m_x + 32*c;
               y0 = m_y + 32*r;
               if (m_alive[r*COLS + c] && bx >= x0 && bx <= x0 + 15 && by >= y0 && by <= y0 + 15)
                  hit_i = r*COLS + c;
            end
      if (cnt == 0) m_state = 2;
      else if (m_y + 32*brow + 15 >= 440) m_state = 1;
      else if (frame) begin
         if (m_cnt >= (1 + (cnt >> 2)) - 1) begin
            m_cnt = 0;
            step  = 1;
         end else m_cnt++;
      end
      if (step) begin
         m_anim = ~m_anim;
         if (m_dir > 0) begin
            if (m_x + 32*rcol + 15 + 4 <= 639) m_x += 4;
            else begin m_y += 16; m_dir = -1; end
         end else begin
            if (m_x + 32*lcol - 4 >= 0) m_x -= 4;
            else begin m_y += 16; m_dir = 1; end
         end
      end
      if (hit_i >= 0) begin
         m_alive[hit_i] = 0;
         m_coll = 1;
         m_hidx = hit_i;
      end
   endtask

   task automatic compare_all();
      logic [N-1:0] ea;
      for (int i = 0; i < N; i++) ea[i] = m_alive[i];
      chk("fleet_x",   fleet_x, m_x);
      chk("fleet_y",   fleet_y, m_y);
      chk("alive",     alive, ea);
      chk("anim",      anim, m_anim);
      chk("collision", invader_collision, m_coll);
      chk("hit_index", hit_index, m_hidx);
      chk("landed",    landed, m_state == 1);
      chk("cleared",   cleared, m_state == 2);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle();
      frame = 0; restart = 0; bullet_valid = 0;
   endtask

   task automatic do_restart();
      idle();
      restart = 1;
      tick();
      restart = 0;
   endtask

   // Aim a bullet at a random pixel inside the sprite of cell idx
   task automatic fire(input int idx, input bit with_frame);
      bullet_valid = 1;
      bullet_x = 10'(m_x + 32*(idx % COLS) + $urandom_range(0, 15));
      bullet_y = 10'(m_y + 32*(idx / COLS) + $urandom_range(0, 15));
      frame = with_frame;
      tick();
      idle();
   endtask

   task automatic march_until_drop(input int y0);
      frame = 1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (fleet_y != 10'(y0)) break;
      end
      frame = 0;
   endtask

   initial begin
      int order[N];
      int tmp, j, saved_x;

      rst = 0; bullet_x = 0; bullet_y = 0;
      idle();
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      rst = 1;
      repeat (3) tick();

      // Step cadence: 55 alive -> 14 frames per step
      for (int i = 0; i < 14; i++) begin
         frame = 1; tick();
         frame = 0; tick();
         if (i == 12) chk("tp_x_before_14th", fleet_x, 64);
      end
      chk("tp_x_after_14", fleet_x, 68);
      chk("tp_anim_after_14", anim, 1);

      // Hit at reset origin, held bullet, gap miss
      do_restart();
      bullet_valid = 1; bullet_x = 131; bullet_y = 85;
      tick();
      chk("tp_hit_pulse", invader_collision, 1);
      chk("tp_hit_index", hit_index, 13);
      chk("tp_alive13", alive[13], 0);
      tick();
      chk("tp_no_rehit", invader_collision, 0);
      bullet_x = 84; bullet_y = 50;
      tick();
      chk("tp_gap_miss", invader_collision, 0);
      idle();

      // Right reversal at full width
      march_until_drop(48);
      chk("tp_rev_x", fleet_x, 304);
      chk("tp_rev_y", fleet_y, 64);
      frame = 1;
      for (int i = 0; i < 100 && fleet_x == 10'd304; i++) tick();
      frame = 0;
      chk("tp_moving_left", fleet_x, 300);

      // Right edge follows live columns
      do_restart();
      for (int r = 0; r < ROWS; r++) fire(r*COLS + 10, 0);
      march_until_drop(48);
      chk("tp_rev_x_col9", fleet_x, 336);

      // Clear the wave in random order with random frames
      do_restart();
      for (int i = 0; i < N; i++) order[i] = i;
      for (int i = N - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < N; i++) fire(order[i], 1'($urandom_range(0, 1)));
      chk("tp_last_hit", invader_collision, 1);
      chk("tp_clear_not_yet", cleared, 0);
      tick();
      chk("tp_cleared", cleared, 1);
      saved_x = int'(fleet_x);
      frame = 1;
      repeat (40) tick();
      frame = 0;
      chk("tp_clear_frozen", fleet_x, saved_x);
      do_restart();
      chk("tp_restart_alive", alive, {N{1'b1}});
      chk("tp_restart_x", fleet_x, 64);
      chk("tp_restart_y", fleet_y, 48);
      chk("tp_restart_clr", cleared, 0);

      // Landing with only row 0 alive
      for (int i = COLS; i < N; i++) fire(i, 0);
      frame = 1;
      for (int i = 0; i < 20000 && !landed; i++) tick();
      frame = 0;
      chk("tp_landed", landed, 1);
      chk("tp_land_y", fleet_y, 432);

      // Asynchronous reset mid-cycle
      frame = 1;
      @(posedge clk);
      model_edge();
      #3;
      rst = 0;
      idle();
      model_reset();
      #1;
      compare_all();
      chk("tp_async_landed", landed, 0);
      repeat (2) begin @(posedge clk); #1; compare_all(); end
      rst = 1;
      repeat (3) tick();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         restart = ($urandom_range(0, 299) == 0);
         frame   = ($urandom_range(0, 2) == 0);
         bullet_valid = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0) begin
            bullet_x = 10'(m_x + 32*$urandom_range(0, COLS - 1) + $urandom_range(0, 31));
            bullet_y = 10'(m_y + 32*$urandom_range(0, ROWS - 1) + $urandom_range(0, 31));
         end else begin
            bullet_x = 10'($urandom_range(0, 1023));
            bullet_y = 10'($urandom_range(0, 1023));
         end
         tick();
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
